// File: rtl/add_round_key_stage.sv
// ---------------------------------------------------------------------------
// add_round_key_stage: registered AddRoundKey behind a 2-entry skid buffer.
// Optional round-sequence checker: ARK_ROUND_SEQ_CHECK_EN.   Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module add_round_key_stage #(
  parameter int NUM_ROUNDS = 10,
  parameter int RW         = 4
) (
  input  logic                          clock,
  input  logic                          reset_n,
  input  logic                          inValid,
  output logic                          inReady,
  input  logic [127:0]                  inState,
  input  logic [RW-1:0]                 inRound,
  input  logic [128*(NUM_ROUNDS+1)-1:0] roundKeys,
  output logic                          outValid,
  input  logic                          outReady,
  output logic [127:0]                  outState,
  output logic [RW-1:0]                 outRound,
  output logic                          outRoundErr,
  output logic                          seqErr
);

  localparam logic [RW-1:0] LAST_ROUND = RW'(NUM_ROUNDS);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } buf_state_t;

  buf_state_t     state;
  logic [127:0]   round_key;
  logic [127:0]   xored;
  logic           round_err;
  logic           accept;
  logic           emit;
  logic [127:0]   skid_state;
  logic [RW-1:0]  skid_round;
  logic           skid_err;

  // Out-of-range round indices match no entry and therefore use an all-zero key.
  always_comb begin
    round_key = '0;
    for (int r = 0; r <= NUM_ROUNDS; r++) begin
      if (inRound == RW'(r)) round_key = roundKeys[128*r +: 128];
    end
  end

  assign round_err = (inRound > LAST_ROUND);
  assign xored     = inState ^ round_key;
  assign accept    = inValid & inReady;
  assign emit      = outValid & outReady;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= EMPTY;
      inReady     <= 1'b1;
      outValid    <= 1'b0;
      outState    <= '0;
      outRound    <= '0;
      outRoundErr <= 1'b0;
      skid_state  <= '0;
      skid_round  <= '0;
      skid_err    <= 1'b0;
    end else begin
      case (state)
        EMPTY: begin
          if (accept) begin
            outState    <= xored;
            outRound    <= inRound;
            outRoundErr <= round_err;
            outValid    <= 1'b1;
            state       <= ONE;
          end
        end
        ONE: begin
          if (accept && emit) begin
            outState    <= xored;
            outRound    <= inRound;
            outRoundErr <= round_err;
          end else if (accept) begin
            skid_state <= xored;
            skid_round <= inRound;
            skid_err   <= round_err;
            inReady    <= 1'b0;
            state      <= TWO;
          end else if (emit) begin
            outValid <= 1'b0;
            state    <= EMPTY;
          end
        end
        TWO: begin
          if (emit) begin
            outState    <= skid_state;
            outRound    <= skid_round;
            outRoundErr <= skid_err;
            inReady     <= 1'b1;
            state       <= ONE;
          end
        end
        default: begin
          state    <= EMPTY;
          inReady  <= 1'b1;
          outValid <= 1'b0;
        end
      endcase
    end
  end

`ifdef ARK_ROUND_SEQ_CHECK_EN
  logic [RW-1:0] expected_round;
  logic          seq_err;

  // Counter resynchronises to whatever round arrived, so one gap flags once.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      expected_round <= '0;
      seq_err        <= 1'b0;
    end else if (accept) begin
      if (inRound != expected_round) seq_err <= 1'b1;
      expected_round <= (inRound == LAST_ROUND) ? '0 : inRound + 1'b1;
    end
  end

  assign seqErr = seq_err;

  a_no_accept_in_two: assert property (@(posedge clock) disable iff (!reset_n)
    !(accept && state == TWO));
`else
  assign seqErr = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_add_round_key_stage.sv
// ---------------------------------------------------------------------------
// tb_add_round_key_stage: directed + randomized bench with a FIFO reference model.
// ---------------------------------------------------------------------------
`default_nettype none

module tb_add_round_key_stage;

  localparam int NR = 10;
`ifdef ARK_ROUND_SEQ_CHECK_EN
  localparam bit SEQ_EN = 1'b1;
`else
  localparam bit SEQ_EN = 1'b0;
`endif

  logic                  clock = 1'b0;
  logic                  reset_n;
  logic                  inValid;
  logic                  inReady;
  logic [127:0]          inState;
  logic [3:0]            inRound;
  logic [128*(NR+1)-1:0] roundKeys;
  logic                  outValid;
  logic                  outReady;
  logic [127:0]          outState;
  logic [3:0]            outRound;
  logic                  outRoundErr;
  logic                  seqErr;

  logic [127:0] keys [0:NR];

  always #5 clock = ~clock;

  always_comb begin
    roundKeys = '0;
    for (int r = 0; r <= NR; r++) roundKeys[128*r +: 128] = keys[r];
  end

  add_round_key_stage #(.NUM_ROUNDS(NR), .RW(4)) dut (
    .clock(clock), .reset_n(reset_n),
    .inValid(inValid), .inReady(inReady), .inState(inState), .inRound(inRound),
    .roundKeys(roundKeys),
    .outValid(outValid), .outReady(outReady), .outState(outState),
    .outRound(outRound), .outRoundErr(outRoundErr), .seqErr(seqErr)
  );

  typedef struct packed {
    logic [127:0] st;
    logic [3:0]   rnd;
    logic         err;
  } beat_t;

  beat_t q[$];
  int    checks = 0;
  int    errors = 0;
  bit    last_acc = 1'b0;
  bit    seq_flag = 1'b0;
  int    seq_exp  = 0;

  function automatic logic [127:0] rand128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  function automatic beat_t model_beat(logic [127:0] s, logic [3:0] r);
    beat_t b;
    b.rnd = r;
    b.err = (int'(r) > NR);
    b.st  = b.err ? s : (s ^ keys[int'(r)]);
    return b;
  endfunction

  task automatic chk(string tag, logic [127:0] obs, logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Compare against the model, then advance one clock and update the model.
  task automatic cycle();
    bit    acc;
    bit    emt;
    beat_t nb;
    chk("inReady", inReady, q.size() < 2);
    chk("outValid", outValid, q.size() > 0);
    if (q.size() > 0) begin
      chk("outState", outState, q[0].st);
      chk("outRound", outRound, q[0].rnd);
      chk("outRoundErr", outRoundErr, q[0].err);
    end
    chk("seqErr", seqErr, seq_flag & SEQ_EN);
    acc = inValid && (q.size() < 2);
    emt = outReady && (q.size() > 0);
    nb  = model_beat(inState, inRound);
    @(posedge clock);
    #1;
    if (emt) void'(q.pop_front());
    if (acc) begin
      q.push_back(nb);
      if (int'(inRound) != seq_exp) seq_flag = 1'b1;
      seq_exp = (int'(inRound) == NR) ? 0 : (int'(inRound) + 1) % 16;
    end
    last_acc = acc;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    #2;
    chk("rst_outValid", outValid, 0);
    chk("rst_inReady", inReady, 1);
    chk("rst_outState", outState, 0);
    chk("rst_outRound", outRound, 0);
    chk("rst_outRoundErr", outRoundErr, 0);
    chk("rst_seqErr", seqErr, 0);
    q.delete();
    seq_flag = 1'b0;
    seq_exp  = 0;
    last_acc = 1'b0;
    @(posedge clock);
    #1;
    reset_n = 1'b1;
  endtask

  task automatic drain();
    inValid  = 1'b0;
    outReady = 1'b1;
    repeat (3) cycle();
  endtask

  initial begin
    reset_n  = 1'b1;
    inValid  = 1'b0;
    inState  = '0;
    inRound  = '0;
    outReady = 1'b0;
    for (int r = 0; r <= NR; r++) keys[r] = rand128();
    #1;
    do_reset();

    // FIPS-197 Appendix B, round 0
    keys[0]  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    outReady = 1'b1;
    inValid  = 1'b1;
    inState  = 128'h3243f6a8885a308d313198a2e0370734;
    inRound  = 4'd0;
    cycle();
    chk("fips_round0", outState, 128'h193de3bea0f4e22b9ac68d2ae9f84808);
    drain();

    // Rounds 0..10 back-to-back
    do_reset();
    outReady = 1'b1;
    inValid  = 1'b1;
    for (int r = 0; r <= NR; r++) begin
      inState = rand128();
      inRound = 4'(r);
      cycle();
    end
    drain();

    // Skid fill: three beats against a stalled sink
    outReady = 1'b0;
    inValid  = 1'b1;
    inState = rand128(); inRound = 4'd1; cycle();
    inState = rand128(); inRound = 4'd2; cycle();
    inState = rand128(); inRound = 4'd3; cycle();
    cycle();
    outReady = 1'b1;
    cycle();
    cycle();
    inValid = 1'b0;
    cycle();
    cycle();

    // Out-of-range rounds, followed by a legal one
    inValid = 1'b1;
    inState = rand128(); inRound = 4'd15; cycle();
    inState = rand128(); inRound = 4'd11; cycle();
    inState = rand128(); inRound = 4'd4;  cycle();
    drain();

    // Round sequence 0,1,3
    do_reset();
    outReady = 1'b1;
    inValid  = 1'b1;
    inState = rand128(); inRound = 4'd0; cycle();
    inState = rand128(); inRound = 4'd1; cycle();
    inState = rand128(); inRound = 4'd3; cycle();
    drain();
    chk("seqErr_sticky", seqErr, SEQ_EN);
    do_reset();
    chk("seqErr_cleared", seqErr, 0);

    // Randomized traffic with occasional key updates
    for (int i = 0; i < 400; i++) begin
      if (last_acc || !inValid) begin
        inValid = ($urandom_range(0, 3) != 0);
        inState = rand128();
        inRound = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(11, 15))
                                              : 4'($urandom_range(0, NR));
      end
      outReady = ($urandom_range(0, 2) != 0);
      if ($urandom_range(0, 9) == 0) keys[$urandom_range(0, NR)] = rand128();
      cycle();
    end
    drain();

    // Reset while both entries are full
    outReady = 1'b0;
    inValid  = 1'b1;
    inState = rand128(); inRound = 4'd5; cycle();
    inState = rand128(); inRound = 4'd6; cycle();
    inValid = 1'b0;
    chk("two_before_reset", inReady, 0);
    do_reset();
    outReady = 1'b1;
    repeat (3) cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
